// File: rtl/tz_pkg.sv
// Shared TrustZone attribute encodings and types for the read-data path.
package tz_pkg;

    localparam logic TZ_SECURE    = 1'b0;
    localparam logic TZ_NONSECURE = 1'b1;

    localparam int TZ_DW = 32;

    // Tagged response word at the default SoC data width.
    typedef struct packed {
        logic [TZ_DW-1:0] data;
        logic             ns;
    } tz_rsp_t;

    // Resulting level of a paired response: secure only if both sides are secure.
    function automatic logic tz_level(input logic tag_ns, input logic rsp_ns);
        return tag_ns | rsp_ns;
    endfunction

    // A non-secure requester receiving secure data is a leak.
    function automatic logic tz_leak(input logic tag_ns, input logic rsp_ns);
        return (tag_ns == TZ_NONSECURE) && (rsp_ns == TZ_SECURE);
    endfunction

endpackage

// File: rtl/tz_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers.
module tz_sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer advance; a push while full or a pop while empty is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents are don't-care while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/tz_rdata_stage.sv
// Read-response stage: pairs in-order request security tags with returning
// responses, blocks secure-to-non-secure leaks and counts violations.
module tz_rdata_stage
    import tz_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_ns,
    input  logic          rsp_valid,
    output logic          rsp_ready,
    input  logic [DW-1:0] rsp_data,
    input  logic          rsp_ns,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] rdata,
    output logic          rdata_security_level,
    output logic          viol_pulse,
    output logic [CW-1:0] viol_count
);

    // Same layout as tz_rsp_t, sized to this instance's data width.
    typedef struct packed {
        logic [DW-1:0] data;
        logic          ns;
    } rsp_t;

    logic tag_full, tag_empty, tag_head;
    logic tag_push, tag_pop;

    logic data_full, data_empty;
    logic data_push, data_pop;
    rsp_t data_in, data_head;

    logic rsp_acc;
    logic viol;

    assign req_ready = !tag_full;
    assign rsp_ready = !data_full;
    assign tag_push  = req_valid && req_ready;
    assign rsp_acc   = rsp_valid && rsp_ready;

    tz_sync_fifo #(
        .WIDTH (1),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tag_push),
        .din   (req_ns),
        .pop   (tag_pop),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // Pairing and policy: an accepted response consumes the head tag, or is an orphan.
    always_comb begin
        tag_pop   = 1'b0;
        data_push = 1'b0;
        data_in   = '0;
        viol      = 1'b0;
        if (rsp_acc) begin
            if (tag_empty) begin
                viol = 1'b1;
            end else begin
                tag_pop      = 1'b1;
                data_push    = 1'b1;
                data_in.ns   = tz_level(tag_head, rsp_ns);
                data_in.data = tz_leak(tag_head, rsp_ns) ? '0 : rsp_data;
                viol         = tz_leak(tag_head, rsp_ns);
            end
        end
    end

    assign data_pop = out_valid && out_ready;

    tz_sync_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (data_push),
        .din   (data_in),
        .pop   (data_pop),
        .dout  (data_head),
        .full  (data_full),
        .empty (data_empty)
    );

    // Output view: head entry when valid, otherwise zero data at non-secure level.
    always_comb begin
        out_valid            = !data_empty;
        rdata                = '0;
        rdata_security_level = TZ_NONSECURE;
        if (!data_empty) begin
            rdata                = data_head.data;
            rdata_security_level = data_head.ns;
        end
    end

    // Registered violation pulse and saturating counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            viol_pulse <= 1'b0;
            viol_count <= '0;
        end else begin
            viol_pulse <= viol;
            if (viol && (viol_count != '1))
                viol_count <= viol_count + CW'(1);
        end
    end

endmodule
